display_scan_driver: RTL and testbench

- Producer side of the 7-segment digit-select/digit-value interface: converts a binary value into three BCD digits and time-multiplexes them onto the `mostrar`/`digito` pair consumed by the segment/anode decoder.
- Sits between the ultrasonic distance measurement logic (0..999 cm) and the display decoder.
- Uses a sequential double-dabble converter and a refresh divider.

---
 rtl/display_pkg.sv | 26 ++
 rtl/bin2bcd_seq.sv | 87 ++++++++
 rtl/display_scan_driver.sv | 84 ++++++++
 tb/tb_display_scan_driver.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and helpers for the 7-segment scan driver and its BCD converter.
// Pure definitions: no logic, no latency.
package display_pkg;

    localparam logic [1:0] SEL_HUND = 2'b01;
    localparam logic [1:0] SEL_TENS = 2'b10;
    localparam logic [1:0] SEL_UNIT = 2'b11;

    localparam int MAX_DISPLAY = 999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        for (int n = 0; n < 3; n++) begin
            r[n*4 +: 4] = (b[n*4 +: 4] >= 4'd5) ? b[n*4 +: 4] + 4'd3 : b[n*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: clamps the input to 999, then VAL_W shift edges and one DONE edge.
// start is only honoured in IDLE; done is high for exactly the DONE-state cycle.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int VAL_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [11:0]      bcd,
    output logic             clamped
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    conv_state_e          state_q;
    logic [VAL_W-1:0]     bin_q;
    logic [11:0]          bcd_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 clamped_q;
    logic [11+VAL_W:0]    shift_d;
    logic                 over_max;

    assign shift_d  = {add3(bcd_q), bin_q} << 1;
    assign over_max = int'(bin) > MAX_DISPLAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bcd_q   <= '0;
                        if (over_max) begin
                            bin_q     <= VAL_W'(MAX_DISPLAY);
                            clamped_q <= 1'b1;
                        end else begin
                            bin_q     <= bin;
                            clamped_q <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= shift_d;
                    cnt_q          <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(VAL_W - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd     = bcd_q;
    assign clamped = clamped_q;

endmodule

// File: rtl/display_scan_driver.sv
// Converts valor to three BCD digits and scans them onto mostrar/digito, REFRESH_DIV cycles per digit.
// New value appears VAL_W+1 cycles after an accepted load; loads while busy are dropped.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int VAL_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] valor,
    input  logic             load,
    output logic             busy,
    output logic             overflow,
    output logic [1:0]       mostrar,
    output logic [3:0]       digito
);

    localparam int RW = $clog2(REFRESH_DIV);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [11:0]   disp_q, disp_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    digito_q, digito_d;
    logic          conv_done;
    logic          conv_clamped;
    logic [11:0]   conv_bcd;

    bin2bcd_seq #(.VAL_W(VAL_W)) u_conv (
        .clk     (clk),
        .rst     (rst),
        .start   (load),
        .bin     (valor),
        .busy    (busy),
        .done    (conv_done),
        .bcd     (conv_bcd),
        .clamped (conv_clamped)
    );

    always_comb begin
        rcnt_d = rcnt_q + 1'b1;
        sel_d  = sel_q;
        if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
            rcnt_d = '0;
            case (sel_q)
                SEL_HUND: sel_d = SEL_TENS;
                SEL_TENS: sel_d = SEL_UNIT;
                default:  sel_d = SEL_HUND;
            endcase
        end

        disp_d = conv_done ? conv_bcd : disp_q;
        ovf_d  = conv_done ? conv_clamped : ovf_q;

        // Next-state select and display keep digito aligned with mostrar on every cycle.
        case (sel_d)
            SEL_HUND: digito_d = disp_d[11:8];
            SEL_TENS: digito_d = disp_d[7:4];
            default:  digito_d = disp_d[3:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q   <= '0;
            sel_q    <= SEL_HUND;
            disp_q   <= '0;
            ovf_q    <= 1'b0;
            digito_q <= '0;
        end else begin
            rcnt_q   <= rcnt_d;
            sel_q    <= sel_d;
            disp_q   <= disp_d;
            ovf_q    <= ovf_d;
            digito_q <= digito_d;
        end
    end

    assign mostrar  = sel_q;
    assign overflow = ovf_q;
    assign digito   = digito_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomised and directed bench for display_scan_driver against an arithmetic reference model.
module tb_display_scan_driver;

    localparam int RD = 4;
    localparam int VW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [VW-1:0] valor;
    logic          load;
    logic          busy;
    logic          overflow;
    logic [1:0]    mostrar;
    logic [3:0]    digito;

    int total = 0;
    int bad   = 0;

    // Reference model state: edges since reset, pending conversion, shown value.
    int m_t, m_left, m_val, m_disp;
    bit m_busy, m_pend, m_ovf;

    display_scan_driver #(.REFRESH_DIV(RD), .VAL_W(VW)) dut (
        .clk      (clk),
        .rst      (rst),
        .valor    (valor),
        .load     (load),
        .busy     (busy),
        .overflow (overflow),
        .mostrar  (mostrar),
        .digito   (digito)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] exp_vec();
        int pos, d;
        pos = (m_t / RD) % 3;
        if (pos == 0)      d = m_disp / 100;
        else if (pos == 1) d = (m_disp / 10) % 10;
        else               d = m_disp % 10;
        return {m_busy, m_ovf, 2'(pos + 1), 4'(d)};
    endfunction

    task automatic tick(input logic r, input logic l, input logic [VW-1:0] v);
        rst   = r;
        load  = l;
        valor = v;
        @(posedge clk);
        if (r) begin
            m_t = 0; m_busy = 0; m_left = 0; m_disp = 0; m_ovf = 0; m_pend = 0;
        end else begin
            m_t++;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_disp = m_val;
                    m_ovf  = m_pend;
                end
            end else if (l) begin
                m_pend = int'(v) > 999;
                m_val  = m_pend ? 999 : int'(v);
                m_busy = 1;
                m_left = VW + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 17; i++) begin
            tick((i < 3) || (i >= 9 && i < 12), 1'b0, '0);
            total++;
            if ({busy, overflow, mostrar, digito} !== exp_vec()) begin
                bad++;
                $display("FAIL reset cyc%0d got=%h exp=%h", i, {busy, overflow, mostrar, digito}, exp_vec());
            end
        end
    endtask

    task automatic test_conversion();
        int nbusy = 0;
        for (int i = 0; i < 44; i++) begin
            tick(1'b0, i == 0, 10'd456);
            if (i < 14 && busy === 1'b1) nbusy++;
            total++;
            if ({busy, overflow, mostrar, digito} !== exp_vec()) begin
                bad++;
                $display("FAIL conv cyc%0d got=%h exp=%h", i, {busy, overflow, mostrar, digito}, exp_vec());
            end
            if (i >= 14) begin
                total++;
                if (digito !== (mostrar == 2'b01 ? 4'd4 : mostrar == 2'b10 ? 4'd5 : 4'd6) || mostrar === 2'b00) begin
                    bad++;
                    $display("FAIL conv_digit cyc%0d sel=%b got=%0d", i, mostrar, digito);
                end
            end
        end
        total++;
        if (nbusy !== 11) begin
            bad++;
            $display("FAIL busy_len got=%0d exp=11", nbusy);
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, i == 0 || i == 13, (i == 0) ? 10'd1000 : 10'd7);
            total++;
            if ({busy, overflow, mostrar, digito} !== exp_vec()) begin
                bad++;
                $display("FAIL clamp cyc%0d got=%h exp=%h", i, {busy, overflow, mostrar, digito}, exp_vec());
            end
        end
    endtask

    task automatic test_load_while_busy();
        logic [VW-1:0] v;
        for (int i = 0; i < 38; i++) begin
            v = (i == 0) ? 10'd123 : (i == 3) ? 10'd888 : 10'd55;
            tick(1'b0, i == 0 || i == 3 || i == 12, v);
            total++;
            if ({busy, overflow, mostrar, digito} !== exp_vec()) begin
                bad++;
                $display("FAIL busy_load cyc%0d got=%h exp=%h", i, {busy, overflow, mostrar, digito}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 36; i++) begin
            tick(i == 5, i == 0 || i == 8, (i == 0) ? 10'd999 : 10'd250);
            total++;
            if ({busy, overflow, mostrar, digito} !== exp_vec()) begin
                bad++;
                $display("FAIL rst_mid cyc%0d got=%h exp=%h", i, {busy, overflow, mostrar, digito}, exp_vec());
            end
        end
    endtask

    task automatic test_boundaries();
        logic [VW-1:0] v;
        for (int i = 0; i < 52; i++) begin
            v = (i == 0) ? 10'd0 : (i == 13) ? 10'd999 : 10'd1023;
            tick(1'b0, i == 0 || i == 13 || i == 26, v);
            total++;
            if ({busy, overflow, mostrar, digito} !== exp_vec()) begin
                bad++;
                $display("FAIL bound cyc%0d got=%h exp=%h", i, {busy, overflow, mostrar, digito}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 249) == 0, $urandom_range(0, 5) == 0, VW'($urandom_range(0, 1023)));
            total++;
            if ({busy, overflow, mostrar, digito} !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc%0d got=%h exp=%h", i, {busy, overflow, mostrar, digito}, exp_vec());
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        valor = '0;
        test_reset();
        test_conversion();
        test_clamp();
        test_load_while_busy();
        test_reset_mid();
        test_boundaries();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
